// File: rtl/lcd_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_sequencer
//   Drives the character-LCD write block. After reset it idles for the LCD
//   power-up time, issues the four-byte HD44780 init sequence, then accepts one
//   command/data byte at a time from the processor over a req/ack handshake.
//   Every issued byte is followed by the LCD execution time before anything
//   else is issued.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            synchronous active-low reset
//   req              processor request, held high until ack
//   req_rs           0 = command byte, 1 = data byte
//   req_data         byte to write
//   ack              one-cycle pulse: request accepted and issued
//   busy             high whenever the sequencer is not idle
//   init_done        high once the init sequence has completed (sticky)
//   lcd_instruction  32'h0 = command, 32'h1 = data
//   lcd_data         {24'h0, byte}
//   lcd_en           one-cycle issue strobe to the write block
// -----------------------------------------------------------------------------
module lcd_sequencer #(
  parameter int POWERUP_WAIT = 1_000_000,
  parameter int CMD_WAIT     = 2_500,
  parameter int CLR_WAIT     = 82_000,
  parameter int CNT_W        = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_rs,
  input  logic [7:0]  req_data,
  output logic        ack,
  output logic        busy,
  output logic        init_done,
  output logic [31:0] lcd_instruction,
  output logic [31:0] lcd_data,
  output logic        lcd_en
);

  typedef enum logic [1:0] {
    PWRUP,
    INIT_ISSUE,
    WAIT,
    IDLE
  } state_t;

  localparam logic [2:0] INIT_LEN = 3'd4;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             en_d, ack_d, busy_d, init_done_d;
  logic [31:0]      instr_d, data_d;
  logic [7:0]       rom_byte;

  // Function set 8-bit/2-line, display on, entry mode increment, clear.
  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Counter load for a byte is N-1: the WAIT state lasts N cycles, starting
  // with the lcd_en cycle. Clear (0x01) and home (0x02/0x03) are the slow ones.
  function automatic logic [CNT_W-1:0] wait_load(input logic rs, input logic [7:0] b);
    if (!rs && (b[7:2] == 6'd0) && (b != 8'd0))
      return CNT_W'(CLR_WAIT - 1);
    else
      return CNT_W'(CMD_WAIT - 1);
  endfunction

  assign rom_byte = init_rom(idx_q[1:0]);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    en_d        = 1'b0;
    ack_d       = 1'b0;
    instr_d     = lcd_instruction;
    data_d      = lcd_data;
    init_done_d = init_done;

    case (state_q)
      PWRUP: begin
        if (cnt_q == CNT_W'(POWERUP_WAIT - 1)) begin
          state_d = INIT_ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      INIT_ISSUE: begin
        en_d    = 1'b1;
        instr_d = 32'h0;
        data_d  = {24'h0, rom_byte};
        cnt_d   = wait_load(1'b0, rom_byte);
        idx_d   = idx_q + 3'd1;
        state_d = WAIT;
      end

      WAIT: begin
        if (cnt_q == '0) begin
          // init_done doubles as the "user traffic" flag: during init a
          // finished wait either fetches the next ROM byte or ends init.
          if (init_done) begin
            state_d = IDLE;
          end else if (idx_q == INIT_LEN) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d = INIT_ISSUE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      IDLE: begin
        if (req) begin
          en_d    = 1'b1;
          ack_d   = 1'b1;
          instr_d = {31'b0, req_rs};
          data_d  = {24'h0, req_data};
          cnt_d   = wait_load(req_rs, req_data);
          state_d = WAIT;
        end
      end

      default: state_d = PWRUP;
    endcase

    // busy is registered from the next state so that it reads 0 in the cycle
    // right after a reset edge and follows the state register afterwards.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q         <= PWRUP;
      cnt_q           <= '0;
      idx_q           <= '0;
      lcd_en          <= 1'b0;
      ack             <= 1'b0;
      busy            <= 1'b0;
      init_done       <= 1'b0;
      lcd_instruction <= 32'h0;
      lcd_data        <= 32'h0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      lcd_en          <= en_d;
      ack             <= ack_d;
      busy            <= busy_d;
      init_done       <= init_done_d;
      lcd_instruction <= instr_d;
      lcd_data        <= data_d;
    end
  end

endmodule
